// File: rtl/smux_seq.sv
// ---------------------------------------------------------------------------
// smux_seq -- sequenced time-slot multiplexer.
//
// Walks N_CH input channels in order and holds each one for SLOT_LEN cycles.
// One full pass over all channels is a frame. Each selected sample is
// registered onto data_out one cycle after the counter state that chose it.
// mux_flag is only looked at in IDLE, to start, and at the last cycle of a
// frame, to decide whether the next frame follows with no gap. Dropping it
// mid-frame never cuts the frame short.
//
// Optional feature (macro SMUX_SEQ_BYPASS_EN): bypass_en / bypass_ch force a
// fixed channel onto data_out every cycle and freeze the sequencer.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   bypass_en   in   (SMUX_SEQ_BYPASS_EN only) force bypass_ch onto data_out
//   bypass_ch   in   (SMUX_SEQ_BYPASS_EN only) bypass channel; >= N_CH -> 0
//   mux_flag    in   run request
//   data_in     in   N_CH packed channels, channel k at [k*WIDTH +: WIDTH]
//   data_out    out  registered selected channel
//   out_valid   out  data_out carries a sequenced sample this cycle
//   ch_sel      out  channel index shown on data_out
//   frame_done  out  pulse alongside the last sample of a frame
//   busy        out  sequencer is in RUN
// ---------------------------------------------------------------------------
module smux_seq #(
  parameter  int WIDTH    = 136,
  parameter  int N_CH     = 3,
  parameter  int SLOT_LEN = 4,
  localparam int CH_W     = (N_CH > 2)     ? $clog2(N_CH)     : 1,
  localparam int SL_W     = (SLOT_LEN > 2) ? $clog2(SLOT_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SMUX_SEQ_BYPASS_EN
  input  logic                  bypass_en,
  input  logic [CH_W-1:0]       bypass_ch,
`endif
  input  logic                  mux_flag,
  input  logic [N_CH*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  out_valid,
  output logic [CH_W-1:0]       ch_sel,
  output logic                  frame_done,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q,      state_d;
  logic [SL_W-1:0]   slot_q,       slot_d;
  logic [CH_W-1:0]   ch_q,         ch_d;
  logic [WIDTH-1:0]  data_out_q,   data_out_d;
  logic [CH_W-1:0]   ch_sel_q,     ch_sel_d;
  logic              out_valid_q,  out_valid_d;
  logic              frame_done_q, frame_done_d;

  logic              slot_last;
  logic              ch_last;
  logic              byp_active;
  logic [CH_W-1:0]   byp_ch;
  logic [CH_W-1:0]   rd_ch;
  logic [WIDTH-1:0]  rd_data;

`ifdef SMUX_SEQ_BYPASS_EN
  assign byp_active = bypass_en;
  // Out-of-range bypass requests fall back to channel 0.
  assign byp_ch     = (int'(bypass_ch) < N_CH) ? bypass_ch : '0;
`else
  assign byp_active = 1'b0;
  assign byp_ch     = '0;
`endif

  assign slot_last = (slot_q == SL_W'(SLOT_LEN - 1));
  assign ch_last   = (ch_q   == CH_W'(N_CH - 1));
  assign rd_ch     = byp_active ? byp_ch : ch_q;

  // Channel read mux. Only legal channel codes match, so a code that the
  // counters cannot reach never indexes past the top of data_in.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch;
    // a path that leaves a variable unassigned would infer a latch.
    rd_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (rd_ch == CH_W'(k)) rd_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    ch_d         = ch_q;
    data_out_d   = data_out_q;  // data_out and ch_sel hold when idle
    ch_sel_d     = ch_sel_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (byp_active) begin
      // Bypass: fixed channel every cycle, sequencer frozen.
      data_out_d  = rd_data;
      ch_sel_d    = rd_ch;
      out_valid_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mux_flag) begin
            state_d = RUN;
            slot_d  = '0;
            ch_d    = '0;
          end
        end
        RUN: begin
          data_out_d   = rd_data;
          ch_sel_d     = ch_q;
          out_valid_d  = 1'b1;
          frame_done_d = slot_last && ch_last;
          if (slot_last) begin
            slot_d = '0;
            if (ch_last) begin
              // Frame end: continue straight into the next frame or stop.
              ch_d = '0;
              if (!mux_flag) state_d = IDLE;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      ch_q         <= '0;
      data_out_q   <= '0;
      ch_sel_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ch_q         <= ch_d;
      data_out_q   <= data_out_d;
      ch_sel_q     <= ch_sel_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign ch_sel     = ch_sel_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_smux_seq.sv
// ---------------------------------------------------------------------------
// tb_smux_seq -- directed self-checking bench for smux_seq (default
// parameters). With SMUX_SEQ_BYPASS_EN defined, a second instance
// (N_CH=5, SLOT_LEN=1) exercises the bypass path.
// ---------------------------------------------------------------------------
module tb_smux_seq;

  localparam int WIDTH    = 136;
  localparam int N_CH     = 3;
  localparam int SLOT_LEN = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mux_flag;
  logic [N_CH*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]      data_out;
  logic                  out_valid;
  logic [1:0]            ch_sel;
  logic                  frame_done;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef SMUX_SEQ_BYPASS_EN
  logic       m_byp_en = 1'b0;
  logic [1:0] m_byp_ch = '0;
`endif

  smux_seq #(.WIDTH(WIDTH), .N_CH(N_CH), .SLOT_LEN(SLOT_LEN)) u_dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SMUX_SEQ_BYPASS_EN
    .bypass_en  (m_byp_en),
    .bypass_ch  (m_byp_ch),
`endif
    .mux_flag   (mux_flag),
    .data_in    (data_in),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .ch_sel     (ch_sel),
    .frame_done (frame_done),
    .busy       (busy)
  );

`ifdef SMUX_SEQ_BYPASS_EN
  logic        b_en;
  logic [2:0]  b_ch;
  logic        b_flag = 1'b0;
  logic [79:0] b_data_in;
  logic [15:0] b_data_out;
  logic        b_valid;
  logic [2:0]  b_ch_sel;
  logic        b_done;
  logic        b_busy;

  smux_seq #(.WIDTH(16), .N_CH(5), .SLOT_LEN(1)) u_byp (
    .clk        (clk),
    .rst        (rst),
    .bypass_en  (b_en),
    .bypass_ch  (b_ch),
    .mux_flag   (b_flag),
    .data_in    (b_data_in),
    .data_out   (b_data_out),
    .out_valid  (b_valid),
    .ch_sel     (b_ch_sel),
    .frame_done (b_done),
    .busy       (b_busy)
  );
`endif

  task automatic check(input string tag, input logic [135:0] obs,
                       input logic [135:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [135:0] ch_val(input int k);
    return 136'hA + 136'(k);
  endfunction

  initial begin
    data_in = '0;
    for (int k = 0; k < N_CH; k++) data_in[k*WIDTH +: WIDTH] = ch_val(k);
`ifdef SMUX_SEQ_BYPASS_EN
    b_en = 1'b0;
    b_ch = '0;
    for (int k = 0; k < 5; k++) b_data_in[k*16 +: 16] = 16'h100 + 16'(k);
`endif

    // Reset for 2 cycles with data present and mux_flag high: rst wins.
    rst      = 1'b1;
    mux_flag = 1'b1;
    tick();
    check("rst_prio_busy", busy, 0);
    tick();
    check("rst_data_out", data_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_done", frame_done, 0);
    rst      = 1'b0;
    mux_flag = 1'b0;
    tick();
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);

    // Single frame from a one-cycle mux_flag pulse.
    mux_flag = 1'b1;
    tick();
    check("sf_busy_start", busy, 1);
    check("sf_valid_start", out_valid, 0);
    mux_flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("sf_valid", out_valid, 1);
      check("sf_data", data_out, ch_val(i / 4));
      check("sf_ch_sel", ch_sel, 136'(i / 4));
      check("sf_done", frame_done, (i == 11) ? 1 : 0);
      check("sf_busy", busy, (i == 11) ? 0 : 1);
    end
    tick();
    check("sf_after_valid", out_valid, 0);
    check("sf_after_done", frame_done, 0);
    check("sf_after_hold", data_out, ch_val(2));
    check("sf_after_ch", ch_sel, 2);

    // Back-to-back frames: mux_flag high for 30 samples, no gaps.
    mux_flag = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) begin
      tick();
      check("b2b_valid", out_valid, 1);
      check("b2b_ch_sel", ch_sel, 136'((i / 4) % 3));
      check("b2b_data", data_out, ch_val((i / 4) % 3));
      check("b2b_done", frame_done, (i % 12 == 11) ? 1 : 0);
    end
    // Counters now sit at channel 1 slot 2: drop mux_flag mid-frame.
    mux_flag = 1'b0;
    for (int p = 6; p < 12; p++) begin
      tick();
      check("drop_valid", out_valid, 1);
      check("drop_ch_sel", ch_sel, 136'(p / 4));
      check("drop_done", frame_done, (p == 11) ? 1 : 0);
    end
    tick();
    check("drop_end_valid", out_valid, 0);
    check("drop_end_hold", data_out, ch_val(2));
    check("drop_end_busy", busy, 0);

    // Reset mid-frame at channel 1 slot 0.
    mux_flag = 1'b1;
    tick();
    mux_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_ch0", ch_sel, 0);
    end
    rst = 1'b1;
    tick();
    check("mr_data_out", data_out, 0);
    check("mr_valid", out_valid, 0);
    check("mr_ch_sel", ch_sel, 0);
    check("mr_done", frame_done, 0);
    check("mr_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("mr_no_done", frame_done, 0);
      check("mr_no_valid", out_valid, 0);
    end

`ifdef SMUX_SEQ_BYPASS_EN
    // Bypass on a 5-channel, 1-slot instance.
    b_en = 1'b1;
    b_ch = 3'd3;
    tick();
    check("byp_data3", b_data_out, 16'h103);
    check("byp_valid", b_valid, 1);
    check("byp_ch3", b_ch_sel, 3);
    check("byp_done", b_done, 0);
    check("byp_busy", b_busy, 0);
    b_ch = 3'd6;
    tick();
    check("byp_data_oor", b_data_out, 16'h100);
    check("byp_ch_oor", b_ch_sel, 0);
    b_en = 1'b0;
    tick();
    check("byp_off_valid", b_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
